banked_mem_ctrl: RTL and testbench

Parametrised, banked, synchronous memory with one instruction read port and one handshaked data port that supports direct and indirect (pointer-through-memory) reads and writes. It replaces the flat combinational memory in the CPU datapath. All reads are registered, and indirect accesses are sequenced by a small state machine instead of a combinational double lookup. The core fetch unit connects to the instruction port; the load/store unit connects to the data port.

---
 rtl/banked_mem_if.sv | 29 ++
 rtl/banked_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_banked_mem_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/banked_mem_if.sv
// Bus bundle for banked_mem_ctrl: free-running fetch port plus handshaked data port.
interface banked_mem_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic              d_indirect;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   modport master (
      output i_req, i_addr, d_req, d_we, d_indirect, d_addr, d_wdata,
      input  i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_indirect, d_addr, d_wdata,
      output i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata
   );
endinterface

// File: rtl/banked_mem_ctrl.sv
// Banked synchronous memory: registered instruction fetch port and a data port
// that sequences indirect (pointer-through-memory) reads/writes with a small FSM.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready; direct accesses complete here, indirect ones latch
//   ST_PTR    | read pointer word at the latched address into ptr
//   ST_ACCESS | read or write the word that ptr addresses, then back to idle
module banked_mem_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 12,
   parameter int BANK_BITS = 2
) (
   input logic          clk,
   input logic          rst_n,
   banked_mem_if.slave  bus
);
   localparam int NUM_BANKS      = 2**BANK_BITS;
   localparam int IDX_W          = ADDR_W - BANK_BITS - 1;
   localparam int WORDS_PER_BANK = 2**IDX_W;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PTR    = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] ptr;

   logic [DATA_W-1:0] mem [NUM_BANKS][WORDS_PER_BANK];

   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_word;
   logic              accept;
   logic              wr_en;
   logic              unused_bits;

   assign bus.d_ready = (state == ST_IDLE);
   assign accept      = bus.d_req && (state == ST_IDLE);

   // One data-side read and at most one write per cycle; the FSM state picks the address.
   always_comb begin
      rd_addr = bus.d_addr;
      wr_addr = bus.d_addr;
      wr_data = bus.d_wdata;
      case (state)
         ST_PTR: rd_addr = lat_addr;
         ST_ACCESS: begin
            rd_addr = ptr[ADDR_W-1:0];
            wr_addr = ptr[ADDR_W-1:0];
            wr_data = lat_wdata;
         end
         default: ;
      endcase
   end

   assign rd_word = mem[rd_addr[ADDR_W-1 -: BANK_BITS]][rd_addr[IDX_W:1]];

   // rst_n gates the write so nothing lands in the array while reset is held.
   assign wr_en = rst_n &&
                  ((accept && bus.d_we && !bus.d_indirect) ||
                   (state == ST_ACCESS && lat_we));

   // Pointer high bits and address bit 0 are deliberately ignored.
   assign unused_bits = ^{rd_addr[0], wr_addr[0], bus.i_addr[0], ptr};

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr[ADDR_W-1 -: BANK_BITS]][wr_addr[IDX_W:1]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.i_rvalid <= 1'b0;
         bus.i_rdata  <= '0;
      end else begin
         bus.i_rvalid <= bus.i_req;
         if (bus.i_req)
            bus.i_rdata <= mem[bus.i_addr[ADDR_W-1 -: BANK_BITS]][bus.i_addr[IDX_W:1]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         lat_addr     <= '0;
         lat_we       <= 1'b0;
         lat_wdata    <= '0;
         ptr          <= '0;
         bus.d_rvalid <= 1'b0;
         bus.d_rdata  <= '0;
      end else begin
         bus.d_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.d_req) begin
                  if (bus.d_indirect) begin
                     lat_addr  <= bus.d_addr;
                     lat_we    <= bus.d_we;
                     lat_wdata <= bus.d_wdata;
                     state     <= ST_PTR;
                  end else if (!bus.d_we) begin
                     bus.d_rdata  <= rd_word;
                     bus.d_rvalid <= 1'b1;
                  end
               end
            end
            ST_PTR: begin
               ptr   <= rd_word;
               state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (!lat_we) begin
                  bus.d_rdata  <= rd_word;
                  bus.d_rvalid <= 1'b1;
               end
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Directed bench for banked_mem_ctrl: default 16/12/2 instance plus a 32/14/3 instance.
module tb_banked_mem_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   banked_mem_if #(.DATA_W(16), .ADDR_W(12)) bus_a ();
   banked_mem_if #(.DATA_W(32), .ADDR_W(14)) bus_b ();

   banked_mem_ctrl #(.DATA_W(16), .ADDR_W(12), .BANK_BITS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a));
   banked_mem_ctrl #(.DATA_W(32), .ADDR_W(14), .BANK_BITS(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge where the transaction has completed.
   task automatic a_txn(input logic we, input logic ind, input logic [11:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output int lat, output int rdy_low);
      logic done;
      done    = 1'b0;
      rdata   = '0;
      lat     = 0;
      rdy_low = 0;
      bus_a.d_req      = 1'b1;
      bus_a.d_we       = we;
      bus_a.d_indirect = ind;
      bus_a.d_addr     = addr;
      bus_a.d_wdata    = wdata;
      @(posedge clk);
      #1 bus_a.d_req = 1'b0;
      for (int c = 1; c <= 8 && !done; c++) begin
         @(negedge clk);
         if (!bus_a.d_ready) rdy_low++;
         if (bus_a.d_rvalid) begin
            rdata = bus_a.d_rdata;
            lat   = c;
         end
         if (bus_a.d_ready && (we || bus_a.d_rvalid)) done = 1'b1;
      end
      check("a_txn_complete", done, 1);
   endtask

   task automatic a_wr(input logic [11:0] addr, input logic [15:0] wdata);
      logic [15:0] r;
      int l, rl;
      a_txn(1'b1, 1'b0, addr, wdata, r, l, rl);
   endtask

   task automatic b_txn(input logic we, input logic [13:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
      bus_b.d_req      = 1'b1;
      bus_b.d_we       = we;
      bus_b.d_indirect = 1'b0;
      bus_b.d_addr     = addr;
      bus_b.d_wdata    = wdata;
      @(posedge clk);
      #1 bus_b.d_req = 1'b0;
      @(negedge clk);
      check("b_rvalid", bus_b.d_rvalid, {31'd0, ~we});
      rdata = bus_b.d_rdata;
   endtask

   logic [11:0] a_addrs [4] = '{12'h3FE, 12'h400, 12'h7FE, 12'hFFE};
   logic [15:0] a_vals  [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
   logic [13:0] b_addrs [4] = '{14'h07FE, 14'h0800, 14'h0FFE, 14'h3FFE};
   logic [31:0] b_vals  [4] = '{32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] r;
      logic [31:0] rb;
      int lat, rl;

      rst_n = 1'b0;
      bus_a.i_req = 0; bus_a.i_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
      bus_a.d_indirect = 0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
      bus_b.i_req = 0; bus_b.i_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
      bus_b.d_indirect = 0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
      repeat (2) @(negedge clk);

      check("rst_d_ready",  bus_a.d_ready,  1);
      check("rst_d_rvalid", bus_a.d_rvalid, 0);
      check("rst_i_rvalid", bus_a.i_rvalid, 0);
      check("rst_d_rdata",  bus_a.d_rdata,  0);
      check("rst_i_rdata",  bus_a.i_rdata,  0);
      rst_n = 1'b1;

      // direct write/read, pulse width, hold, alias
      a_wr(12'h402, 16'h1234);
      a_txn(1'b0, 1'b0, 12'h402, '0, r, lat, rl);
      check("direct_rd_data", r, 16'h1234);
      check("direct_rd_lat",  lat, 1);
      @(negedge clk);
      check("d_rvalid_pulse", bus_a.d_rvalid, 0);
      check("d_rdata_hold",   bus_a.d_rdata, 16'h1234);
      a_txn(1'b0, 1'b0, 12'h403, '0, r, lat, rl);
      check("alias_403", r, 16'h1234);

      // indirect read then back-to-back direct read
      a_wr(12'h400, 16'h0806);
      a_wr(12'h806, 16'hBEEF);
      a_txn(1'b0, 1'b1, 12'h400, '0, r, lat, rl);
      check("ind_rd_data",  r, 16'hBEEF);
      check("ind_rd_lat",   lat, 3);
      check("ind_rd_ready_low", rl, 2);
      a_txn(1'b0, 1'b0, 12'h402, '0, r, lat, rl);
      check("b2b_rd_lat",  lat, 1);
      check("b2b_rd_data", r, 16'h1234);

      // indirect write
      a_wr(12'hC00, 16'h0A10);
      a_txn(1'b1, 1'b1, 12'hC00, 16'h5A5A, r, lat, rl);
      check("ind_wr_ready_low", rl, 2);
      a_txn(1'b0, 1'b0, 12'hA10, '0, r, lat, rl);
      check("ind_wr_target", r, 16'h5A5A);
      a_txn(1'b0, 1'b0, 12'hC00, '0, r, lat, rl);
      check("ind_wr_ptr_kept", r, 16'h0A10);

      // self-referencing pointer
      a_wr(12'h600, 16'h0600);
      a_txn(1'b0, 1'b1, 12'h600, '0, r, lat, rl);
      check("self_ptr", r, 16'h0600);

      // fetch/write collision: read-before-write
      a_wr(12'h010, 16'h1111);
      bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_indirect = 0;
      bus_a.d_addr = 12'h010; bus_a.d_wdata = 16'h2222;
      bus_a.i_req = 1; bus_a.i_addr = 12'h010;
      @(posedge clk);
      #1 bus_a.d_req = 0; bus_a.i_req = 0;
      @(negedge clk);
      check("fetch_rvalid", bus_a.i_rvalid, 1);
      check("fetch_old",    bus_a.i_rdata, 16'h1111);
      bus_a.i_req = 1;
      @(posedge clk);
      #1 bus_a.i_req = 0;
      @(negedge clk);
      check("fetch_new", bus_a.i_rdata, 16'h2222);
      @(negedge clk);
      check("fetch_idle_rvalid", bus_a.i_rvalid, 0);
      check("fetch_hold",        bus_a.i_rdata, 16'h2222);

      // reset during PTR of an indirect write (0x400 -> 0x806)
      a_wr(12'h400, 16'h0806);
      bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_indirect = 1;
      bus_a.d_addr = 12'h400; bus_a.d_wdata = 16'h7777;
      bus_a.i_req = 1; bus_a.i_addr = 12'h402;
      @(posedge clk);
      #1 bus_a.d_req = 0; bus_a.i_req = 0;
      check("ptr_state_ready", bus_a.d_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ready",    bus_a.d_ready,  1);
      check("mid_rst_d_rvalid", bus_a.d_rvalid, 0);
      check("mid_rst_i_rvalid", bus_a.i_rvalid, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      a_txn(1'b0, 1'b0, 12'h806, '0, r, lat, rl);
      check("abandoned_wr_target", r, 16'hBEEF);
      a_txn(1'b0, 1'b0, 12'h400, '0, r, lat, rl);
      check("abandoned_wr_ptr", r, 16'h0806);

      // bank boundaries, default parameters
      for (int k = 0; k < 4; k++) a_wr(a_addrs[k], a_vals[k]);
      for (int k = 0; k < 4; k++) begin
         a_txn(1'b0, 1'b0, a_addrs[k], '0, r, lat, rl);
         check($sformatf("bank_a_%0h", a_addrs[k]), r, a_vals[k]);
      end

      // bank boundaries, 32/14/3 instance
      for (int k = 0; k < 4; k++) b_txn(1'b1, b_addrs[k], b_vals[k], rb);
      for (int k = 0; k < 4; k++) begin
         b_txn(1'b0, b_addrs[k], '0, rb);
         check($sformatf("bank_b_%0h", b_addrs[k]), rb, b_vals[k]);
      end

      // indirect read on the wide instance: 0x1000 holds pointer 0x3FFE
      b_txn(1'b1, 14'h1000, 32'h0000_3FFE, rb);
      bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_indirect = 1; bus_b.d_addr = 14'h1000;
      @(posedge clk);
      #1 bus_b.d_req = 0;
      repeat (3) @(negedge clk);
      check("b_ind_rvalid", bus_b.d_rvalid, 1);
      check("b_ind_data",   bus_b.d_rdata, 32'hDEAD0004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
